router_out_arbiter: RTL and testbench

- Per-output-port round-robin arbiter for the Cardinal router VC datapath. One instance per output port (N, S, E, W, PE).
- Each cycle it picks at most one input-port request whose target output VC buffer has space, and grants it during phase_internal.
- The grant drives the input-buffer dequeue and output-buffer enqueue in the same cycle, then advances the fairness pointer.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_out_arbiter_if.sv | 31 +++
 rtl/router_out_arbiter_rr_prio_pick.sv | 48 ++++
 rtl/router_out_arbiter.sv | 63 ++++++
 tb/tb_router_out_arbiter.sv | 134 +++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared router constants: port indices and packet field positions.
package router_pkg;

    localparam int unsigned PORT_N    = 0;
    localparam int unsigned PORT_S    = 1;
    localparam int unsigned PORT_E    = 2;
    localparam int unsigned PORT_W    = 3;
    localparam int unsigned PORT_PE   = 4;
    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned NUM_VC    = 2;

    // Packet field positions within the 64-bit flit.
    localparam int unsigned VC_BIT     = 63;
    localparam int unsigned DX_BIT     = 62;
    localparam int unsigned DY_BIT     = 61;
    localparam int unsigned HX_MSB     = 55;
    localparam int unsigned HX_LSB     = 52;
    localparam int unsigned HY_MSB     = 51;
    localparam int unsigned HY_LSB     = 48;
    localparam int unsigned SX_MSB     = 47;
    localparam int unsigned SX_LSB     = 40;
    localparam int unsigned SY_MSB     = 39;
    localparam int unsigned SY_LSB     = 32;
    localparam int unsigned PAYLOAD_MSB = 31;
    localparam int unsigned PAYLOAD_LSB = 0;

endpackage

// File: rtl/router_out_arbiter_if.sv
// Request/grant bundle between the router datapath and one output arbiter.
interface router_out_arbiter_if
    import router_pkg::*;
#(
    parameter int unsigned NUM_IN = NUM_PORTS,
    parameter int unsigned IDX_W  = 3
);

    logic                phase_internal;
    logic [NUM_IN-1:0]   req;
    logic [NUM_IN-1:0]   req_vc;
    logic [NUM_VC-1:0]   obuf_full;
    logic [NUM_IN-1:0]   gnt;
    logic                gnt_valid;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_vc;
    logic [IDX_W-1:0]    rr_ptr;

    // Datapath side: raises requests, consumes grants.
    modport master (
        output phase_internal, req, req_vc, obuf_full,
        input  gnt, gnt_valid, gnt_idx, gnt_vc, rr_ptr
    );

    // Arbiter side.
    modport slave (
        input  phase_internal, req, req_vc, obuf_full,
        output gnt, gnt_valid, gnt_idx, gnt_vc, rr_ptr
    );

endinterface

// File: rtl/router_out_arbiter_rr_prio_pick.sv
// Round-robin pick: first set elig bit scanning from ptr upward, wrapping.
module rr_prio_pick
    import router_pkg::*;
#(
    parameter int unsigned NUM_IN = NUM_PORTS,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [NUM_IN-1:0] elig_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] onehot_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    // Rotate by ptr, take the first hit, map back to the absolute index.
    always_comb begin
        int unsigned base;
        int unsigned pos;
        logic [IDX_W-1:0] pos_idx;
        logic found;

        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        found    = 1'b0;
        pos      = 0;
        pos_idx  = '0;
        // An out-of-range pointer is treated as 0.
        base     = (ptr_i > LAST_IDX) ? 0 : 32'(ptr_i);

        for (int unsigned k = 0; k < NUM_IN; k++) begin
            pos = base + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            pos_idx = IDX_W'(pos);
            if (!found && elig_i[pos_idx]) begin
                found             = 1'b1;
                onehot_o[pos_idx] = 1'b1;
                idx_o             = pos_idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter with VC-full skipping and phase gating.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_IN = NUM_PORTS,
    parameter int unsigned IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    router_out_arbiter_if.slave   arb
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              grant;

    // A request is eligible only if its target VC buffer has room.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            elig[i] = arb.req[i] & ~arb.obuf_full[arb.req_vc[i]];
        end
    end

    rr_prio_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .elig_i   (elig),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Grant qualification and next pointer (one past the winner, wrapping).
    always_comb begin
        grant    = arb.phase_internal & ~reset & pick_any;
        rr_ptr_d = (pick_idx >= LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
    end

    // Pointer advances only on an actual grant so idle cycles keep fairness.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign arb.gnt       = grant ? pick_onehot : '0;
    assign arb.gnt_valid = grant;
    assign arb.gnt_idx   = grant ? pick_idx : '0;
    assign arb.gnt_vc    = grant & (|(pick_onehot & arb.req_vc));
    assign arb.rr_ptr    = reset ? '0 : rr_ptr_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed vector bench for router_out_arbiter.
module tb_router_out_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    router_out_arbiter_if #(.NUM_IN(5), .IDX_W(3)) bus ();

    router_out_arbiter #(.NUM_IN(5), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ph;
        logic [4:0] req;
        logic [4:0] vc;
        logic [1:0] full;
        logic [4:0] gnt;
        logic [2:0] idx;
        logic       gvc;
        logic [2:0] ptr;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic check_outputs(input int n, input logic [4:0] g, input logic [2:0] i,
                                 input logic v, input logic [2:0] p);
        check("gnt",       n, 8'(bus.gnt),       8'(g));
        check("gnt_valid", n, 8'(bus.gnt_valid), 8'(|g));
        check("gnt_idx",   n, 8'(bus.gnt_idx),   8'(i));
        check("gnt_vc",    n, 8'(bus.gnt_vc),    8'(v));
        check("rr_ptr",    n, 8'(bus.rr_ptr),    8'(p));
    endtask

    initial begin
        logic [2:0] exp_idx;
        logic [4:0] exp_gnt;

        checks = 0;
        errors = 0;

        // rst ph req vc full | gnt idx gvc ptr(before edge)
        vecs[0]  = '{1'b1, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b1, 5'b00100, 5'b00000, 2'b00, 5'b00100, 3'd2, 1'b0, 3'd0};
        vecs[3]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd3};
        vecs[4]  = '{1'b0, 1'b1, 5'b10000, 5'b00000, 2'b00, 5'b10000, 3'd4, 1'b0, 3'd3};
        vecs[5]  = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00001, 3'd0, 1'b0, 3'd0};
        vecs[6]  = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00010, 3'd1, 1'b0, 3'd1};
        vecs[7]  = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00100, 3'd2, 1'b0, 3'd2};
        vecs[8]  = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b01000, 3'd3, 1'b0, 3'd3};
        vecs[9]  = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b10000, 3'd4, 1'b0, 3'd4};
        vecs[10] = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00001, 3'd0, 1'b0, 3'd0};
        vecs[11] = '{1'b0, 1'b0, 5'b11111, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd1};
        vecs[12] = '{1'b0, 1'b1, 5'b10000, 5'b00000, 2'b00, 5'b10000, 3'd4, 1'b0, 3'd1};
        vecs[13] = '{1'b0, 1'b0, 5'b00011, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd0};
        vecs[14] = '{1'b0, 1'b1, 5'b00011, 5'b00000, 2'b00, 5'b00001, 3'd0, 1'b0, 3'd0};
        vecs[15] = '{1'b0, 1'b0, 5'b00011, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd1};
        vecs[16] = '{1'b0, 1'b1, 5'b00011, 5'b00000, 2'b00, 5'b00010, 3'd1, 1'b0, 3'd1};
        vecs[17] = '{1'b0, 1'b0, 5'b00011, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd2};
        vecs[18] = '{1'b0, 1'b1, 5'b10000, 5'b00000, 2'b00, 5'b10000, 3'd4, 1'b0, 3'd2};
        vecs[19] = '{1'b0, 1'b1, 5'b00011, 5'b00001, 2'b10, 5'b00010, 3'd1, 1'b0, 3'd0};
        vecs[20] = '{1'b0, 1'b1, 5'b00011, 5'b00001, 2'b11, 5'b00000, 3'd0, 1'b0, 3'd2};
        vecs[21] = '{1'b0, 1'b1, 5'b00011, 5'b00001, 2'b11, 5'b00000, 3'd0, 1'b0, 3'd2};
        vecs[22] = '{1'b0, 1'b1, 5'b00011, 5'b00001, 2'b01, 5'b00001, 3'd0, 1'b1, 3'd2};
        vecs[23] = '{1'b0, 1'b1, 5'b01000, 5'b00000, 2'b00, 5'b01000, 3'd3, 1'b0, 3'd1};
        vecs[24] = '{1'b0, 1'b1, 5'b10001, 5'b00000, 2'b00, 5'b10000, 3'd4, 1'b0, 3'd4};
        vecs[25] = '{1'b0, 1'b1, 5'b10001, 5'b00000, 2'b00, 5'b00001, 3'd0, 1'b0, 3'd0};
        vecs[26] = '{1'b0, 1'b0, 5'b10001, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd1};
        vecs[27] = '{1'b1, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00000, 3'd0, 1'b0, 3'd0};
        vecs[28] = '{1'b0, 1'b1, 5'b11111, 5'b00000, 2'b00, 5'b00001, 3'd0, 1'b0, 3'd0};
        vecs[29] = '{1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00, 5'b00010, 3'd1, 1'b1, 3'd1};

        reset              = 1'b1;
        bus.phase_internal = 1'b0;
        bus.req            = '0;
        bus.req_vc         = '0;
        bus.obuf_full      = '0;

        // Apply one vector per cycle; outputs sampled mid-cycle before the edge.
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            reset              = vecs[n].rst;
            bus.phase_internal = vecs[n].ph;
            bus.req            = vecs[n].req;
            bus.req_vc         = vecs[n].vc;
            bus.obuf_full      = vecs[n].full;
            #1;
            check_outputs(n, vecs[n].gnt, vecs[n].idx, vecs[n].gvc, vecs[n].ptr);
        end

        // Both buffers full with every input requesting: pointer must hold at 2.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            reset              = 1'b0;
            bus.phase_internal = 1'b1;
            bus.req            = 5'b11111;
            bus.req_vc         = 5'b00000;
            bus.obuf_full      = 2'b11;
            #1;
            check_outputs(100 + n, 5'b00000, 3'd0, 1'b0, 3'd2);
        end

        // Release the buffers: saturated requests rotate through every input from 2.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.obuf_full = 2'b00;
            #1;
            exp_idx = 3'((2 + k) % 5);
            exp_gnt = 5'b00001 << exp_idx;
            check_outputs(200 + k, exp_gnt, exp_idx, 1'b0, exp_idx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
